// File: rtl/whetstone_arbiter.sv
// Round-robin arbiter for a shared whetstone: grants one knight for a fixed
// number of cycles, pulses completion, and counts finished sharpenings.
module whetstone_arbiter #(
  parameter int unsigned N_KNIGHTS      = 4,
  parameter int unsigned SHARPEN_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_KNIGHTS-1:0] req,
  input  logic                 dragon,
  output logic [N_KNIGHTS-1:0] grant,
  output logic [N_KNIGHTS-1:0] sharpened,
  output logic                 busy,
  output logic [7:0]           sharpen_count
);

  localparam int unsigned PTR_W = (N_KNIGHTS > 1) ? $clog2(N_KNIGHTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHARPEN = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e               state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [7:0]           cnt_q;
  logic [N_KNIGHTS-1:0] grant_q;
  logic [N_KNIGHTS-1:0] sharpened_q;
  logic                 busy_q;
  logic [7:0]           count_q;

  logic [PTR_W-1:0]     owner_d;
  logic                 found_d;
  logic [PTR_W-1:0]     owner_next_ptr;
  logic [PTR_W-1:0]     idx;
  int unsigned          sum;

  // First requester at or above rr_ptr, wrapping modulo N_KNIGHTS.
  always_comb begin
    owner_d = '0;
    found_d = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int unsigned k = 0; k < N_KNIGHTS; k++) begin
      sum = (32'(rr_ptr_q) + k) % N_KNIGHTS;
      idx = PTR_W'(sum);
      if (!found_d && req[idx]) begin
        found_d = 1'b1;
        owner_d = idx;
      end
    end
  end

  assign owner_next_ptr = (owner_q == PTR_W'(N_KNIGHTS - 1)) ? '0 : owner_q + PTR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      sharpened_q <= '0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      sharpened_q <= '0;
      case (state_q)
        IDLE: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          if (found_d && !dragon) begin
            owner_q <= owner_d;
            grant_q <= N_KNIGHTS'(1) << owner_d;
            cnt_q   <= 8'(SHARPEN_CYCLES - 1);
            busy_q  <= 1'b1;
            state_q <= SHARPEN;
          end
        end
        SHARPEN: begin
          // Owner letting go of req abandons without credit.
          if (!req[owner_q]) begin
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= owner_next_ptr;
            state_q  <= IDLE;
          end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            grant_q     <= '0;
            sharpened_q <= N_KNIGHTS'(1) << owner_q;
            count_q     <= count_q + 8'd1;
            rr_ptr_q    <= owner_next_ptr;
            state_q     <= DONE;
          end
        end
        DONE: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign sharpened     = sharpened_q;
  assign busy          = busy_q;
  assign sharpen_count = count_q;

endmodule
